// File: rtl/multicycle_ctrl_if.sv
// Handshake and control bundle between the multi-cycle sequencer and the datapath/memories.
// The controller side uses modport master, the datapath side uses modport slave.
interface multicycle_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       opcode;
   logic             imem_ready;
   logic             dmem_ready;
   logic             imem_req;
   logic             dmem_req;
   logic             ir_write;
   logic             pc_write;
   logic [1:0]       alu_op;
   logic             alu_src;
   logic             mem_read;
   logic             mem_write;
   logic             mem_2_reg;
   logic             reg_write;
   logic             branch;
   logic             jump;
   logic             trap;
   logic [1:0]       trap_cause;
   logic [CNT_W-1:0] instret;

   modport master (
      input  opcode, imem_ready, dmem_ready,
      output imem_req, dmem_req, ir_write, pc_write, alu_op, alu_src,
             mem_read, mem_write, mem_2_reg, reg_write, branch, jump,
             trap, trap_cause, instret
   );

   modport slave (
      output opcode, imem_ready, dmem_ready,
      input  imem_req, dmem_req, ir_write, pc_write, alu_op, alu_src,
             mem_read, mem_write, mem_2_reg, reg_write, branch, jump,
             trap, trap_cause, instret
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RISC-V sequencer: FETCH/DECODE/EXEC/MEM/WB with memory-stall timeouts,
// illegal-opcode trap and a retired-instruction counter.
module multicycle_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input logic             clk,
   input logic             arst,
   multicycle_ctrl_if.master bus
);
   localparam int              WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;

   typedef enum logic [2:0] {
      S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   state_t             state_reg, state_next;
   logic [6:0]         op_reg;
   logic [WAIT_W-1:0]  wait_reg;
   logic [1:0]         cause_reg, cause_next;
   logic [CNT_W-1:0]   instret_reg;

   always_comb begin
      state_next     = state_reg;
      cause_next     = cause_reg;
      bus.imem_req   = 1'b0;
      bus.dmem_req   = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.alu_op     = 2'b00;
      bus.alu_src    = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_2_reg  = 1'b0;
      bus.reg_write  = 1'b0;
      bus.branch     = 1'b0;
      bus.jump       = 1'b0;
      bus.trap       = 1'b0;
      unique case (state_reg)
         S_RESET: state_next = S_FETCH;
         S_FETCH: begin
            bus.imem_req = 1'b1;
            if (bus.imem_ready) begin
               bus.ir_write = 1'b1;
               state_next   = S_DECODE;
            end else if (wait_reg == WAIT_LAST) begin
               state_next = S_TRAP;
               cause_next = 2'b01;
            end
         end
         S_DECODE: begin
            if (bus.opcode inside {OP_R, OP_I, OP_BEQ, OP_JAL, OP_LD, OP_ST}) begin
               state_next = S_EXEC;
            end else begin
               state_next = S_TRAP;
               cause_next = 2'b10;
            end
         end
         S_EXEC: begin
            unique case (op_reg)
               OP_R:   begin bus.alu_op = 2'b10; state_next = S_WB; end
               OP_I:   begin bus.alu_src = 1'b1; state_next = S_WB; end
               OP_BEQ: begin
                  bus.alu_op   = 2'b01;
                  bus.branch   = 1'b1;
                  bus.pc_write = 1'b1;
                  state_next   = S_FETCH;
               end
               OP_JAL: begin
                  bus.jump     = 1'b1;
                  bus.pc_write = 1'b1;
                  state_next   = S_FETCH;
               end
               OP_LD, OP_ST: begin bus.alu_src = 1'b1; state_next = S_MEM; end
               default: begin state_next = S_TRAP; cause_next = 2'b10; end
            endcase
         end
         S_MEM: begin
            bus.dmem_req  = 1'b1;
            bus.alu_src   = 1'b1;
            bus.mem_read  = (op_reg == OP_LD);
            bus.mem_write = (op_reg == OP_ST);
            if (bus.dmem_ready) begin
               // A store retires here; a load still needs its writeback cycle.
               if (op_reg == OP_ST) begin
                  bus.pc_write = 1'b1;
                  state_next   = S_FETCH;
               end else begin
                  state_next = S_WB;
               end
            end else if (wait_reg == WAIT_LAST) begin
               state_next = S_TRAP;
               cause_next = 2'b11;
            end
         end
         S_WB: begin
            bus.reg_write = 1'b1;
            bus.pc_write  = 1'b1;
            bus.mem_2_reg = (op_reg == OP_LD);
            bus.alu_op    = (op_reg == OP_R) ? 2'b10 : 2'b00;
            bus.alu_src   = (op_reg != OP_R);
            state_next    = S_FETCH;
         end
         S_TRAP:  bus.trap = 1'b1;
         default: state_next = S_RESET;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_reg   <= S_RESET;
         op_reg      <= 7'd0;
         wait_reg    <= '0;
         cause_reg   <= 2'b00;
         instret_reg <= '0;
      end else begin
         state_reg <= state_next;
         cause_reg <= cause_next;
         if (state_reg == S_DECODE) begin
            op_reg <= bus.opcode;
         end
         // Wait count restarts whenever a FETCH or MEM phase is (re)entered.
         if ((state_reg == S_FETCH || state_reg == S_MEM) && state_next == state_reg) begin
            wait_reg <= wait_reg + 1'b1;
         end else begin
            wait_reg <= '0;
         end
         if (bus.pc_write) begin
            instret_reg <= instret_reg + 1'b1;
         end
      end
   end

   assign bus.trap_cause = cause_reg;
   assign bus.instret    = instret_reg;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction timeline model, directed and random instruction streams.
module tb_multicycle_ctrl;
   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 4;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;

   typedef struct packed {
      logic       imem_req;
      logic       dmem_req;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] alu_op;
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic       mem_2_reg;
      logic       reg_write;
      logic       branch;
      logic       jump;
   } ctrl_t;

   typedef struct {
      logic  imr;
      logic  dmr;
      ctrl_t exp;
   } cyc_t;

   logic clk  = 1'b0;
   logic arst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   model_cnt = 0;
   cyc_t cyc_q[$];
   logic [6:0] ops [6] = '{OP_R, OP_I, OP_BEQ, OP_JAL, OP_LD, OP_ST};

   multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

   multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic ctrl_t observed();
      ctrl_t c;
      c.imem_req  = bus.imem_req;
      c.dmem_req  = bus.dmem_req;
      c.ir_write  = bus.ir_write;
      c.pc_write  = bus.pc_write;
      c.alu_op    = bus.alu_op;
      c.alu_src   = bus.alu_src;
      c.mem_read  = bus.mem_read;
      c.mem_write = bus.mem_write;
      c.mem_2_reg = bus.mem_2_reg;
      c.reg_write = bus.reg_write;
      c.branch    = bus.branch;
      c.jump      = bus.jump;
      return c;
   endfunction

   task automatic push(input logic imr, input logic dmr, input ctrl_t c);
      cyc_t e;
      e.imr = imr;
      e.dmr = dmr;
      e.exp = c;
      cyc_q.push_back(e);
   endtask

   // Timeline of one instruction as a list of per-cycle expected control sets.
   task automatic plan_fetch(input int iw);
      ctrl_t c = '0;
      c.imem_req = 1'b1;
      for (int i = 0; i < iw; i++) push(1'b0, 1'b0, c);
      c.ir_write = 1'b1;
      push(1'b1, 1'b0, c);
   endtask

   task automatic plan_exec(input logic [6:0] op);
      ctrl_t c = '0;
      case (op)
         OP_R:   c.alu_op = 2'b10;
         OP_BEQ: begin c.alu_op = 2'b01; c.branch = 1'b1; c.pc_write = 1'b1; end
         OP_JAL: begin c.jump = 1'b1; c.pc_write = 1'b1; end
         default: c.alu_src = 1'b1;
      endcase
      push(1'b0, 1'b0, c);
   endtask

   task automatic plan_mem(input logic [6:0] op, input int dw, input bit done);
      ctrl_t c = '0;
      c.dmem_req  = 1'b1;
      c.alu_src   = 1'b1;
      c.mem_read  = (op == OP_LD);
      c.mem_write = (op == OP_ST);
      for (int i = 0; i < dw; i++) push(1'b0, 1'b0, c);
      if (done) begin
         c.pc_write = (op == OP_ST);
         push(1'b0, 1'b1, c);
      end
   endtask

   task automatic plan_wb(input logic [6:0] op);
      ctrl_t c = '0;
      c.reg_write = 1'b1;
      c.pc_write  = 1'b1;
      c.mem_2_reg = (op == OP_LD);
      c.alu_op    = (op == OP_R) ? 2'b10 : 2'b00;
      c.alu_src   = (op != OP_R);
      push(1'b0, 1'b0, c);
   endtask

   task automatic run_queue(input string tag);
      cyc_t e;
      logic [CNT_W+2:0] st_obs, st_exp;
      while (cyc_q.size() > 0) begin
         e = cyc_q.pop_front();
         bus.imem_ready = e.imr;
         bus.dmem_ready = e.dmr;
         @(negedge clk);
         checks++;
         assert (observed() === e.exp) else begin
            errors++;
            $error("FAIL %s ctrl got=%b exp=%b", tag, observed(), e.exp);
         end
         st_obs = {bus.trap, bus.trap_cause, bus.instret};
         st_exp = {1'b0, 2'b00, CNT_W'(model_cnt)};
         checks++;
         assert (st_obs === st_exp) else begin
            errors++;
            $error("FAIL %s trap/cause/instret got=%b exp=%b", tag, st_obs, st_exp);
         end
         if (e.exp.pc_write) model_cnt = (model_cnt + 1) % (1 << CNT_W);
         @(posedge clk);
         #1;
      end
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
   endtask

   task automatic run_instr(input logic [6:0] op, input int iw, input int dw, input string tag);
      bus.opcode = op;
      plan_fetch(iw);
      push(1'b0, 1'b0, '0);
      plan_exec(op);
      if (op == OP_LD || op == OP_ST) plan_mem(op, dw, 1'b1);
      if (op == OP_R || op == OP_I || op == OP_LD) plan_wb(op);
      run_queue(tag);
      $display("instr op=%b iw=%0d dw=%0d instret=%0d (%s)", op, iw, dw, bus.instret, tag);
   endtask

   task automatic check_trap(input logic [1:0] cause, input int n, input string tag);
      logic [CNT_W+15:0] obs, exp;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         obs = {bus.trap, bus.trap_cause, observed(), bus.instret};
         exp = {1'b1, cause, 13'd0, CNT_W'(model_cnt)};
         checks++;
         assert (obs === exp) else begin
            errors++;
            $error("FAIL %s trap state got=%b exp=%b", tag, obs, exp);
         end
         @(posedge clk);
         #1;
      end
      $display("trap cause=%b held %0d cycles (%s)", cause, n, tag);
   endtask

   task automatic do_reset(input string tag);
      logic [CNT_W+15:0] obs;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      arst = 1'b1;
      @(negedge clk);
      obs = {bus.trap, bus.trap_cause, observed(), bus.instret};
      checks++;
      assert (obs === '0) else begin
         errors++;
         $error("FAIL %s reset state got=%b exp=0", tag, obs);
      end
      @(posedge clk);
      #1;
      arst = 1'b0;
      model_cnt = 0;
      push(1'b0, 1'b0, '0);
      $display("reset (%s)", tag);
   endtask

   initial begin
      bus.opcode     = OP_I;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;

      do_reset("power_on");
      run_instr(OP_I, 0, 0, "addi");
      run_instr(OP_LD, 0, 3, "lw_wait3");
      run_instr(OP_BEQ, 0, 0, "beq");
      run_instr(OP_JAL, 0, 0, "jal");
      run_instr(OP_ST, 1, 0, "sw");
      run_instr(OP_R, 2, 0, "r_type");

      for (int n = 0; n < 40; n++) begin
         run_instr(ops[$urandom_range(0, 5)], int'($urandom_range(0, TIMEOUT - 1)),
                   int'($urandom_range(0, TIMEOUT - 1)), "random");
      end

      // Instruction fetch never answers: TIMEOUT fetch cycles, then trap.
      do_reset("imem_timeout");
      bus.opcode = OP_I;
      for (int i = 0; i < TIMEOUT; i++) push(1'b0, 1'b0, ctrl_t'(13'h1000));
      run_queue("imem_timeout");
      check_trap(2'b01, 3, "imem_timeout");

      do_reset("imem_last_cycle");
      run_instr(OP_I, TIMEOUT - 1, 0, "imem_ready_last_cycle");

      do_reset("illegal");
      bus.opcode = 7'b1111111;
      plan_fetch(0);
      push(1'b0, 1'b0, '0);
      run_queue("illegal_fetch");
      check_trap(2'b10, 20, "illegal_opcode");
      do_reset("illegal_clear");
      run_instr(OP_R, 0, 0, "after_illegal");

      do_reset("dmem_timeout");
      bus.opcode = OP_ST;
      plan_fetch(0);
      push(1'b0, 1'b0, '0);
      plan_exec(OP_ST);
      plan_mem(OP_ST, TIMEOUT, 1'b0);
      run_queue("dmem_timeout");
      check_trap(2'b11, 3, "dmem_timeout");

      do_reset("dmem_last_cycle");
      run_instr(OP_LD, 0, TIMEOUT - 1, "dmem_ready_last_cycle");

      // Asynchronous reset in the middle of a store's MEM wait.
      do_reset("sw_arst");
      bus.opcode = OP_ST;
      plan_fetch(0);
      push(1'b0, 1'b0, '0);
      plan_exec(OP_ST);
      plan_mem(OP_ST, 2, 1'b0);
      run_queue("sw_pre_arst");
      #2;
      checks++;
      assert ({bus.mem_write, bus.dmem_req} === 2'b11) else begin
         errors++;
         $error("FAIL sw_mid_mem mem_write/dmem_req got=%b exp=11", {bus.mem_write, bus.dmem_req});
      end
      arst = 1'b1;
      #1;
      checks++;
      assert ({observed(), bus.instret} === '0) else begin
         errors++;
         $error("FAIL sw_arst outputs/instret got=%b exp=0", {observed(), bus.instret});
      end
      $display("arst mid-MEM store, instret=%0d", bus.instret);
      @(posedge clk);
      #1;
      arst = 1'b0;
      model_cnt = 0;
      push(1'b0, 1'b0, '0);
      run_instr(OP_I, 0, 0, "after_arst");

      // Counter wrap with a 4-bit instret.
      do_reset("wrap");
      for (int n = 0; n < 16; n++) run_instr(OP_JAL, 0, 0, "jal_wrap");
      checks++;
      assert (bus.instret === 4'd0) else begin
         errors++;
         $error("FAIL instret_wrap got=%0d exp=0", bus.instret);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
